// File: rtl/ingress_rr_arbiter_if.sv
// rtl/ingress_rr_arbiter_if.sv - Stream handshake and grant bundle for the ingress round-robin arbiter
interface ingress_rr_arbiter_if #(
    parameter int NUM_SLAVES = 2,
    parameter int IDX_W      = $clog2(NUM_SLAVES)
);
    logic [NUM_SLAVES-1:0] s_tvalid;
    logic [NUM_SLAVES-1:0] s_tlast;
    logic [NUM_SLAVES-1:0] s_tready;
    logic                  m_tvalid;
    logic                  m_tlast;
    logic                  m_tready;
    logic [NUM_SLAVES-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  busy;

    // Arbiter side
    modport master (
        input  s_tvalid, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tlast, grant, grant_idx, busy
    );

    // Upstream sources, downstream sink and data-mux side
    modport slave (
        output s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tlast, grant, grant_idx, busy
    );
endinterface

// File: rtl/ingress_rr_arbiter.sv
// rtl/ingress_rr_arbiter.sv - Packet-granular round-robin arbiter merging NUM_SLAVES streams into one
// Optional per-port packet counters are enabled by defining INGRESS_ARB_PKT_CNT_EN.
module ingress_rr_arbiter #(
    parameter int NUM_SLAVES = 2,
    parameter int IDX_W      = $clog2(NUM_SLAVES)
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    ingress_rr_arbiter_if.master     bus
`ifdef INGRESS_ARB_PKT_CNT_EN
    ,
    output logic [32*NUM_SLAVES-1:0] pkt_cnt
`endif
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [NUM_SLAVES-1:0] ONE = {{(NUM_SLAVES-1){1'b0}}, 1'b1};

    logic [0:0]            state;
    logic [NUM_SLAVES-1:0] grant_q;
    logic [IDX_W-1:0]      grant_idx_q;
    logic [IDX_W-1:0]      rr_ptr;

    logic [NUM_SLAVES-1:0] arb_req;
    logic [IDX_W-1:0]      arb_ptr;
    logic [IDX_W-1:0]      hi_idx;
    logic [IDX_W-1:0]      lo_idx;
    logic                  hi_found;
    logic                  lo_found;
    logic                  win_any;
    logic [IDX_W-1:0]      win_idx;
    logic [NUM_SLAVES-1:0] win_oh;
    logic                  last_hs;

    assign last_hs = (state == ST_GRANT) && bus.m_tready
                     && ((bus.s_tvalid & bus.s_tlast & grant_q) != '0);

    // While granted, the search starts after the current owner with the owner masked
    // off, so a finishing port yields to any other requester without a bubble.
    always_comb begin
        arb_req  = (state == ST_GRANT) ? (bus.s_tvalid & ~grant_q) : bus.s_tvalid;
        arb_ptr  = (state == ST_GRANT) ? grant_idx_q : rr_ptr;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((arb_req & (ONE << k)) != '0) begin
                if (k > int'(arb_ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(k);
                end
            end
        end
        win_any = hi_found | lo_found;
        win_idx = hi_found ? hi_idx : lo_idx;
        win_oh  = ONE << win_idx;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr      <= IDX_W'(NUM_SLAVES - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        state       <= ST_GRANT;
                        grant_q     <= win_oh;
                        grant_idx_q <= win_idx;
                    end
                end
                default: begin
                    if (last_hs) begin
                        rr_ptr <= grant_idx_q;
                        if (win_any) begin
                            grant_q     <= win_oh;
                            grant_idx_q <= win_idx;
                        end else begin
                            state       <= ST_IDLE;
                            grant_q     <= '0;
                            grant_idx_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

    // grant_q is all-zero in IDLE, which also silences the merged outputs there.
    assign bus.grant     = grant_q;
    assign bus.grant_idx = grant_idx_q;
    assign bus.busy      = (state == ST_GRANT);
    assign bus.m_tvalid  = (bus.s_tvalid & grant_q) != '0;
    assign bus.m_tlast   = (bus.s_tlast & grant_q) != '0;
    assign bus.s_tready  = grant_q & {NUM_SLAVES{bus.m_tready}};

`ifdef INGRESS_ARB_PKT_CNT_EN
    for (genvar p = 0; p < NUM_SLAVES; p++) begin : g_cnt
        logic [31:0] cnt_q;
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                cnt_q <= '0;
            end else if (last_hs && grant_q[p]) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
        assign pkt_cnt[32*p +: 32] = cnt_q;
    end
`endif
endmodule

// File: tb/tb_ingress_rr_arbiter.sv
// tb/tb_ingress_rr_arbiter.sv - Directed self-checking bench for ingress_rr_arbiter (2- and 4-port)
module tb_ingress_rr_arbiter;
    logic aclk;
    logic aresetn;
    int   errors = 0;
    int   checks = 0;

    ingress_rr_arbiter_if #(.NUM_SLAVES(2)) a2 ();
    ingress_rr_arbiter_if #(.NUM_SLAVES(4)) a4 ();

`ifdef INGRESS_ARB_PKT_CNT_EN
    logic [63:0]  cnt2;
    logic [127:0] cnt4;
`endif

    ingress_rr_arbiter #(.NUM_SLAVES(2)) dut2 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (a2)
`ifdef INGRESS_ARB_PKT_CNT_EN
        ,
        .pkt_cnt (cnt2)
`endif
    );

    ingress_rr_arbiter #(.NUM_SLAVES(4)) dut4 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (a4)
`ifdef INGRESS_ARB_PKT_CNT_EN
        ,
        .pkt_cnt (cnt4)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        a2.s_tvalid = '0; a2.s_tlast = '0; a2.m_tready = 1'b0;
        a4.s_tvalid = '0; a4.s_tlast = '0; a4.m_tready = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_inputs();
        step();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        clear_inputs();
        step();
        a2.s_tvalid = 2'b11; a2.s_tlast = 2'b11; a2.m_tready = 1'b1;
        @(negedge aclk);
        checks++; if (a2.grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %0h expected 0", a2.grant); end
        checks++; if (a2.grant_idx !== 1'b0) begin errors++; $display("FAIL rst_grant_idx: got %0h expected 0", a2.grant_idx); end
        checks++; if (a2.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", a2.busy); end
        checks++; if (a2.s_tready !== 2'b00) begin errors++; $display("FAIL rst_s_tready: got %0h expected 0", a2.s_tready); end
        checks++; if (a2.m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %0b expected 0", a2.m_tvalid); end
        checks++; if (a4.grant !== 4'b0000) begin errors++; $display("FAIL rst_grant4: got %0h expected 0", a4.grant); end
        step();
        @(negedge aclk);
        checks++; if (a2.grant !== 2'b00) begin errors++; $display("FAIL rst_hold_grant: got %0h expected 0", a2.grant); end
        step();
        clear_inputs();
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_single_packet();
        int beats = 0;
        a2.s_tvalid = 2'b01; a2.s_tlast = 2'b00; a2.m_tready = 1'b1;
        @(negedge aclk);
        checks++; if (a2.grant !== 2'b00) begin errors++; $display("FAIL sp_latency_grant: got %0h expected 0", a2.grant); end
        checks++; if (a2.m_tvalid !== 1'b0) begin errors++; $display("FAIL sp_latency_m_tvalid: got %0b expected 0", a2.m_tvalid); end
        for (int c = 1; c <= 3; c++) begin
            step();
            a2.s_tlast = (c == 3) ? 2'b01 : 2'b00;
            @(negedge aclk);
            checks++; if (a2.grant !== 2'b01) begin errors++; $display("FAIL sp_grant beat %0d: got %0h expected 1", c, a2.grant); end
            checks++; if (a2.grant_idx !== 1'b0) begin errors++; $display("FAIL sp_grant_idx beat %0d: got %0h expected 0", c, a2.grant_idx); end
            checks++; if (a2.busy !== 1'b1) begin errors++; $display("FAIL sp_busy beat %0d: got %0b expected 1", c, a2.busy); end
            checks++; if (a2.s_tready !== 2'b01) begin errors++; $display("FAIL sp_s_tready beat %0d: got %0h expected 1", c, a2.s_tready); end
            checks++; if (a2.m_tlast !== (c == 3)) begin errors++; $display("FAIL sp_m_tlast beat %0d: got %0b expected %0b", c, a2.m_tlast, (c == 3)); end
            if (a2.m_tvalid && a2.m_tready) beats++;
        end
        step();
        a2.s_tvalid = 2'b00; a2.s_tlast = 2'b00;
        @(negedge aclk);
        checks++; if (a2.busy !== 1'b0) begin errors++; $display("FAIL sp_end_busy: got %0b expected 0", a2.busy); end
        checks++; if (a2.grant !== 2'b00) begin errors++; $display("FAIL sp_end_grant: got %0h expected 0", a2.grant); end
        checks++; if (beats !== 3) begin errors++; $display("FAIL sp_beats: got %0d expected 3", beats); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g [9] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        int bc0 = 0;
        int bc1 = 0;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            a2.s_tvalid = (c == 8) ? 2'b10 : 2'b11;
            a2.s_tlast  = {(bc1 == 1), (bc0 == 1)};
            a2.m_tready = 1'b1;
            @(negedge aclk);
            checks++; if (a2.grant !== exp_g[c]) begin errors++; $display("FAIL b2b_grant cycle %0d: got %0h expected %0h", c, a2.grant, exp_g[c]); end
            if (c > 0) begin
                checks++; if (a2.m_tvalid !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble cycle %0d: got %0b expected 1", c, a2.m_tvalid); end
                checks++; if (a2.m_tlast !== (c % 2 == 0)) begin errors++; $display("FAIL b2b_m_tlast cycle %0d: got %0b expected %0b", c, a2.m_tlast, (c % 2 == 0)); end
            end
            if (exp_g[c][0]) bc0 = (bc0 + 1) % 2;
            if (exp_g[c][1]) bc1 = (bc1 + 1) % 2;
            step();
        end
        a2.s_tvalid = 2'b00; a2.s_tlast = 2'b00;
        @(negedge aclk);
        checks++; if (a2.busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %0b expected 0", a2.busy); end
        step();
    endtask

    task automatic test_backpressure();
        logic rdy [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic v1  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        a2.s_tvalid = 2'b10; a2.s_tlast = 2'b10; a2.m_tready = 1'b0;
        @(negedge aclk);
        checks++; if (a2.grant !== 2'b00) begin errors++; $display("FAIL bp_idle_grant: got %0h expected 0", a2.grant); end
        step();
        for (int c = 1; c <= 6; c++) begin
            a2.s_tvalid = {v1[c], 1'b1}; a2.s_tlast = 2'b11; a2.m_tready = rdy[c];
            @(negedge aclk);
            checks++; if (a2.grant !== 2'b10) begin errors++; $display("FAIL bp_grant cycle %0d: got %0h expected 2", c, a2.grant); end
            checks++; if (a2.s_tready !== {rdy[c], 1'b0}) begin errors++; $display("FAIL bp_s_tready cycle %0d: got %0h expected %0h", c, a2.s_tready, {rdy[c], 1'b0}); end
            checks++; if (a2.m_tvalid !== v1[c]) begin errors++; $display("FAIL bp_m_tvalid cycle %0d: got %0b expected %0b", c, a2.m_tvalid, v1[c]); end
            step();
        end
        a2.s_tvalid = 2'b01; a2.s_tlast = 2'b01; a2.m_tready = 1'b1;
        @(negedge aclk);
        checks++; if (a2.grant !== 2'b01) begin errors++; $display("FAIL bp_switch_grant: got %0h expected 1", a2.grant); end
        checks++; if (a2.m_tlast !== 1'b1) begin errors++; $display("FAIL bp_switch_m_tlast: got %0b expected 1", a2.m_tlast); end
        step();
        a2.s_tvalid = 2'b00; a2.s_tlast = 2'b00;
        @(negedge aclk);
        checks++; if (a2.busy !== 1'b0) begin errors++; $display("FAIL bp_end_busy: got %0b expected 0", a2.busy); end
        step();
    endtask

    task automatic test_four_ports();
        a4.s_tvalid = 4'b1010; a4.s_tlast = 4'b1010; a4.m_tready = 1'b1;
        @(negedge aclk);
        checks++; if (a4.grant !== 4'b0000) begin errors++; $display("FAIL p4_idle_grant: got %0h expected 0", a4.grant); end
        step();
        @(negedge aclk);
        checks++; if (a4.grant !== 4'b0010) begin errors++; $display("FAIL p4_first_grant: got %0h expected 2", a4.grant); end
        checks++; if (a4.grant_idx !== 2'd1) begin errors++; $display("FAIL p4_first_idx: got %0d expected 1", a4.grant_idx); end
        step();
        a4.s_tvalid = 4'b1000; a4.s_tlast = 4'b1000;
        @(negedge aclk);
        checks++; if (a4.grant !== 4'b1000) begin errors++; $display("FAIL p4_second_grant: got %0h expected 8", a4.grant); end
        checks++; if (a4.grant_idx !== 2'd3) begin errors++; $display("FAIL p4_second_idx: got %0d expected 3", a4.grant_idx); end
        checks++; if (a4.m_tvalid !== 1'b1) begin errors++; $display("FAIL p4_no_bubble: got %0b expected 1", a4.m_tvalid); end
        step();
        a4.s_tvalid = 4'b0000; a4.s_tlast = 4'b0000;
        @(negedge aclk);
        checks++; if (a4.busy !== 1'b0) begin errors++; $display("FAIL p4_end_busy: got %0b expected 0", a4.busy); end
        step();
    endtask

    task automatic test_reset_mid_packet();
        a2.s_tvalid = 2'b01; a2.s_tlast = 2'b00; a2.m_tready = 1'b1;
        step();
        @(negedge aclk);
        checks++; if (a2.grant !== 2'b01) begin errors++; $display("FAIL rm_beat1_grant: got %0h expected 1", a2.grant); end
        step();
        aresetn = 1'b0;
        #1;
        checks++; if (a2.grant !== 2'b00) begin errors++; $display("FAIL rm_async_grant: got %0h expected 0", a2.grant); end
        checks++; if (a2.s_tready !== 2'b00) begin errors++; $display("FAIL rm_async_s_tready: got %0h expected 0", a2.s_tready); end
        checks++; if (a2.m_tvalid !== 1'b0) begin errors++; $display("FAIL rm_async_m_tvalid: got %0b expected 0", a2.m_tvalid); end
        checks++; if (a2.busy !== 1'b0) begin errors++; $display("FAIL rm_async_busy: got %0b expected 0", a2.busy); end
        step();
        aresetn = 1'b1;
        a2.s_tvalid = 2'b11; a2.s_tlast = 2'b00;
        @(negedge aclk);
        checks++; if (a2.s_tready !== 2'b00) begin errors++; $display("FAIL rm_post_s_tready: got %0h expected 0", a2.s_tready); end
        checks++; if (a2.m_tvalid !== 1'b0) begin errors++; $display("FAIL rm_post_m_tvalid: got %0b expected 0", a2.m_tvalid); end
        step();
        a2.s_tvalid = 2'b01; a2.s_tlast = 2'b01;
        @(negedge aclk);
        checks++; if (a2.grant !== 2'b01) begin errors++; $display("FAIL rm_winner_grant: got %0h expected 1", a2.grant); end
        checks++; if (a2.grant_idx !== 1'b0) begin errors++; $display("FAIL rm_winner_idx: got %0h expected 0", a2.grant_idx); end
        step();
        a2.s_tvalid = 2'b00; a2.s_tlast = 2'b00;
        @(negedge aclk);
        checks++; if (a2.busy !== 1'b0) begin errors++; $display("FAIL rm_end_busy: got %0b expected 0", a2.busy); end
        step();
    endtask

`ifdef INGRESS_ARB_PKT_CNT_EN
    task automatic test_pkt_cnt();
        do_reset();
        a2.s_tvalid = 2'b10; a2.s_tlast = 2'b10; a2.m_tready = 1'b1;
        for (int c = 0; c < 10; c++) step();
        clear_inputs();
        @(negedge aclk);
        checks++; if (cnt2[63:32] !== 32'd5) begin errors++; $display("FAIL pc_port1: got %0d expected 5", cnt2[63:32]); end
        checks++; if (cnt2[31:0] !== 32'd0) begin errors++; $display("FAIL pc_port0: got %0d expected 0", cnt2[31:0]); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_backpressure();
        test_four_ports();
        test_reset_mid_packet();
`ifdef INGRESS_ARB_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
